// File: rtl/conv_output_streamer.sv
// Captures one flat convolution result frame and streams it out pixel by pixel (index N-1 down to 0) over valid/ready.
// Optional build macro CONV_STREAMER_RELU_EN zeroes negative (sign-bit set) pixels at readout.
`timescale 1ns/1ps
module conv_output_streamer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned OUT_W      = 28,
    parameter int unsigned OUT_H      = 28
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [OUT_W*OUT_H*DATA_WIDTH-1:0]   inputConv,
    output logic                                busy,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic                                done
);

    localparam int unsigned N     = OUT_W * OUT_H;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state;
    logic [IDX_W-1:0]      index;
    logic [IDX_W-1:0]      index_dec;
    logic [DATA_WIDTH-1:0] frame_buf [N];

    assign index_dec = index - IDX_W'(1);

    function automatic logic [DATA_WIDTH-1:0] readout(input logic [DATA_WIDTH-1:0] p);
`ifdef CONV_STREAMER_RELU_EN
        return p[DATA_WIDTH-1] ? '0 : p;
`else
        return p;
`endif
    endfunction

    // Frame snapshot; contents are irrelevant until the next capture, so no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            for (int k = 0; k < int'(N); k++) begin
                frame_buf[k] <= inputConv[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Control FSM with registered stream outputs; the first pixel is taken straight from the input bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            index     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= STREAM;
                        index     <= IDX_W'(N - 1);
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_last  <= 1'(N == 1);
                        out_data  <= readout(inputConv[(N-1)*DATA_WIDTH +: DATA_WIDTH]);
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (index == '0) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            done      <= 1'b1;
                        end else begin
                            index    <= index_dec;
                            out_last <= (index_dec == '0);
                            out_data <= readout(frame_buf[index_dec]);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_output_streamer.sv
// Scoreboard bench for conv_output_streamer: stimulus pushes expected pixels, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_conv_output_streamer;

    localparam int unsigned DW = 16;
    localparam int unsigned W  = 28;
    localparam int unsigned H  = 28;
    localparam int unsigned N  = W * H;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [N*DW-1:0] conv;
    logic            busy, out_valid, out_ready, out_last, done;
    logic [DW-1:0]   out_data;

    logic            start1, ready1, busy1, valid1, last1, done1;
    logic [DW-1:0]   conv1, data1;

    always #5 clk = ~clk;

    conv_output_streamer #(.DATA_WIDTH(DW), .OUT_W(W), .OUT_H(H)) dut (
        .clk(clk), .reset(reset), .start(start), .inputConv(conv), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done));

    conv_output_streamer #(.DATA_WIDTH(DW), .OUT_W(1), .OUT_H(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .inputConv(conv1), .busy(busy1),
        .out_data(data1), .out_valid(valid1), .out_ready(ready1),
        .out_last(last1), .done(done1));

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } exp_t;

    exp_t  q[$];
    exp_t  e;
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    start_cyc, done_cyc, first_valid_cyc, last_xfer_cyc;
    int    xfer_cnt = 0;
    logic  exp_done = 1'b0;
    logic  saw_done = 1'b0;
    logic  prev_valid = 1'b0;
    logic  stall = 1'b0;
    logic [DW-1:0] held_d;
    logic  held_l;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference readout: a negative pixel reads as zero only in the ReLU build.
    function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] p);
`ifdef CONV_STREAMER_RELU_EN
        if (p[DW-1]) return '0;
`endif
        return p;
    endfunction

    // Monitor: one look per cycle, half a period away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("done", done, exp_done);
            if (done) begin
                saw_done = 1'b1;
                done_cyc = cyc;
            end
            exp_done = 1'b0;
            if (q.size() == 0) begin
                chk("idle_valid", out_valid, 0);
                chk("idle_busy", busy, 0);
                chk("idle_last", out_last, 0);
                stall = 1'b0;
            end else begin
                chk("valid", out_valid, 1);
                chk("busy", busy, 1);
                if (out_valid && !prev_valid) first_valid_cyc = cyc;
                if (stall) begin
                    chk("stall_data", out_data, held_d);
                    chk("stall_last", out_last, held_l);
                end
                if (out_valid && out_ready) begin
                    e = q.pop_front();
                    chk("data", out_data, e.d);
                    chk("last", out_last, e.last);
                    if (e.last) begin
                        exp_done = 1'b1;
                        last_xfer_cyc = cyc;
                    end
                    xfer_cnt++;
                    stall = 1'b0;
                end else begin
                    stall  = 1'b1;
                    held_d = out_data;
                    held_l = out_last;
                end
            end
            prev_valid = out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic fill_index();
        for (int k = 0; k < int'(N); k++) conv[k*DW +: DW] = DW'(k);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < int'(N); k++) conv[k*DW +: DW] = DW'($urandom);
    endtask

    // Whole frame leaves in descending pixel order; only pixel 0 carries last.
    task automatic push_frame();
        for (int k = int'(N) - 1; k >= 0; k--) begin
            q.push_back('{d: relu_ref(conv[k*DW +: DW]), last: 1'(k == 0)});
        end
    endtask

    task automatic start_frame();
        @(posedge clk);
        #1;
        start     = 1'b1;
        start_cyc = cyc;
        saw_done  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_frame();
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !saw_done; i++) @(posedge clk);
        chk(name, saw_done, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_data"}, out_data, 0);
    endtask

    initial begin
        logic [DW-1:0] exp0;
        int base;
        reset = 1'b0; start = 1'b0; out_ready = 1'b1; conv = '0;
        start1 = 1'b0; ready1 = 1'b1; conv1 = '0;
        #12;
        check_reset_outputs("rst");
        chk("rst_valid1", valid1, 0);
        @(negedge clk);
        #2 reset = 1'b1;

        // Counting pattern, always ready.
        fill_index();
        start_frame();
        chk("s1_first_data", out_data, 16'h030F);
        wait_done("s1_done", 900);
        chk("s1_cycles", 32'(done_cyc - start_cyc + 1), 786);

        // Ready alternating 1,0,1,0 from the first valid cycle.
        fill_rand();
        out_ready = 1'b1;
        start_frame();
        for (int i = 0; i < 2000 && !saw_done; i++) begin
            @(posedge clk);
            #1 out_ready = ~out_ready;
        end
        chk("s2_done", saw_done, 1);
        chk("s2_cycles", 32'(last_xfer_cyc - first_valid_cyc + 1), 1567);

        // Random data with random back-pressure.
        for (int f = 0; f < 2; f++) begin
            fill_rand();
            out_ready = 1'b1;
            start_frame();
            for (int i = 0; i < 5000 && !saw_done; i++) begin
                @(posedge clk);
                #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            chk("rand_done", saw_done, 1);
        end

        // Start held high from mid-frame with new data: ignored until the done cycle, then taken.
        out_ready = 1'b1;
        fill_rand();
        start_frame();
        repeat (50) @(posedge clk);
        #1;
        fill_rand();
        start = 1'b1;
        wait_done("s3_done_a", 900);
        #1;
        start = 1'b0;
        push_frame();
        chk("s3_restart_valid", out_valid, 1);
        saw_done = 1'b0;
        fill_rand();
        wait_done("s3_done_b", 900);

        // Reset mid-frame after 100 transfers.
        fill_rand();
        start_frame();
        base = xfer_cnt;
        for (int i = 0; i < 400 && (xfer_cnt - base) < 100; i++) @(posedge clk);
        chk("s4_xfers", 32'(xfer_cnt - base), 100);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("s4_async");
        q.delete();
        exp_done = 1'b0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (5) @(posedge clk);
        chk("s4_no_done", saw_done, 0);
        fill_index();
        start_frame();
        chk("s4_first_data", out_data, 16'h030F);
        wait_done("s4_done", 900);

        // Sign-bit handling at readout.
        fill_rand();
        conv[(N-1)*DW +: DW] = 16'hB409;
        conv[(N-2)*DW +: DW] = 16'h346B;
`ifdef CONV_STREAMER_RELU_EN
        exp0 = 16'h0000;
`else
        exp0 = 16'hB409;
`endif
        start_frame();
        chk("s5_px_b409", out_data, exp0);
        @(posedge clk);
        #1 chk("s5_px_346b", out_data, 16'h346B);
        wait_done("s5_done", 900);

        // Single-pixel frame.
        conv1 = 16'hA5C3;
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        chk("s6_valid", valid1, 1);
        chk("s6_last", last1, 1);
        chk("s6_busy", busy1, 1);
        chk("s6_data", data1, relu_ref(16'hA5C3));
        chk("s6_done_early", done1, 0);
        @(posedge clk);
        #1;
        chk("s6_done", done1, 1);
        chk("s6_valid_drop", valid1, 0);
        chk("s6_busy_drop", busy1, 0);
        @(posedge clk);
        #1 chk("s6_done_pulse", done1, 0);

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
